// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter.
// Port ids and lock FSM encodings live here.
package dmem_arb_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam logic [1:0] UNLOCKED = 2'd0;
  localparam logic [1:0] LOCK0    = 2'd1;
  localparam logic [1:0] LOCK1    = 2'd2;

endpackage

// File: rtl/dmem_arb_rr_arb2.sv
// Two-way round-robin picker with a per-port enable mask.
// On a tie the port that did not win last time is chosen.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic [1:0] eff;

  assign eff = req & mask;

  always_comb begin
    gnt = 2'b00;
    unique case (eff)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: gnt = (last_gnt == PORT1) ? 2'b01
                                       : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between MEM stage and a DMA port.
// Build with DMEM_ARB_LOCK_EN to add the per-port bus lock.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef DMEM_ARB_LOCK_EN
  input  logic             m0_lock,
  input  logic             m1_lock,
`endif
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [AW-1:0]    m0_addr,
  input  logic [DW-1:0]    m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [DW-1:0]    m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [AW-1:0]    m1_addr,
  input  logic [DW-1:0]    m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [DW-1:0]    m1_rdata,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic       last_gnt;
  logic [1:0] req;
  logic [1:0] mask;
  logic [1:0] gnt;

  // Gating with rst_n keeps reset cycles from writing memory
  assign req = {m1_req, m0_req} & {2{rst_n}};

`ifdef DMEM_ARB_LOCK_EN
  logic [1:0] lk_q;
  logic [1:0] lk_d;

  always_comb begin
    lk_d = lk_q;
    unique case (lk_q)
      UNLOCKED: begin
        if (gnt[0] && m0_lock)
          lk_d = LOCK0;
        else if (gnt[1] && m1_lock)
          lk_d = LOCK1;
      end
      LOCK0: begin
        if (!m0_req || (gnt[0] && !m0_lock))
          lk_d = UNLOCKED;
      end
      LOCK1: begin
        if (!m1_req || (gnt[1] && !m1_lock))
          lk_d = UNLOCKED;
      end
      default: lk_d = UNLOCKED;
    endcase
  end

  always_comb begin
    mask = 2'b11;
    unique case (lk_q)
      LOCK0:   mask = 2'b01;
      LOCK1:   mask = 2'b10;
      default: mask = 2'b11;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      lk_q <= UNLOCKED;
    else
      lk_q <= lk_d;
  end
`else
  assign mask = 2'b11;
`endif

  rr_arb2 u_rr (
    .req      (req),
    .last_gnt (last_gnt),
    .mask     (mask),
    .gnt      (gnt)
  );

  assign m0_gnt = gnt[PORT0];
  assign m1_gnt = gnt[PORT1];

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (gnt)
      2'b01: begin
        mem_we    = m0_we;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
      end
      2'b10: begin
        mem_we    = m1_we;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

  logic rd0;
  logic rd1;

  assign rd0 = gnt[0] & ~m0_we;
  assign rd1 = gnt[1] & ~m1_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt     <= PORT1;
      m0_rvalid    <= 1'b0;
      m1_rvalid    <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (|gnt)
        last_gnt <= gnt[1];
      m0_rvalid <= rd0;
      m1_rvalid <= rd1;
      if (rd0)
        m0_rdata <= mem_rdata;
      if (rd1)
        m1_rdata <= mem_rdata;
      if (m0_req && m1_req && !(&conflict_cnt))
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single-ported 32x32 data memory between the CPU MEM stage (port 0) and a secondary master such as a DMA or debug loader (port 1).
- Grants at most one memory access per cycle, with round-robin on conflict.
- Drives the memory's write-enable, address and write-data inputs.
- Registers read data back to the winning port and counts conflicts for performance analysis.

Parameters:
- AW, 5, memory address width (32 words).
- DW, 32, data width.
- CNT_W, 16, conflict counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- m0_req  in  1  port 0 access request.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_addr  in  AW  port 0 word address.
- m0_wdata  in  DW  port 0 write data.
- m0_gnt  out  1  port 0 granted this cycle (combinational).
- m0_rvalid  out  1  port 0 read data valid (1-cycle pulse).
- m0_rdata  out  DW  port 0 read data.
- m1_req / m1_we / m1_addr / m1_wdata  in  1/1/AW/DW  port 1 request, same meaning as port 0.
- m1_gnt / m1_rvalid / m1_rdata  out  1/1/DW  port 1 responses, same meaning as port 0.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory combinational read data.
- conflict_cnt  out  CNT_W  saturating count of cycles with both requests high.

Behaviour:
- Clock is clk. Reset is rst_n: synchronous, active-low.
- Reset values:
  - last_gnt register = 1, so port 0 wins the first tie.
  - m0_rvalid = m1_rvalid = 0.
  - m0_rdata = m1_rdata = 0.
  - conflict_cnt = 0.
  - Lock FSM (if compiled in) = UNLOCKED.
- While rst_n = 0: both gnt = 0 and mem_we = 0, so no memory write can occur in a reset cycle.
- Arbitration (combinational, same cycle as request):
  - Only m0_req high -> port 0 wins.
  - Only m1_req high -> port 1 wins.
  - Both high -> the port != last_gnt wins.
  - No request -> no grant.
  - gnt is never asserted without its req.
- Memory drive:
  - mem_addr and mem_wdata come from the winner; with no winner they are 0.
  - mem_we = winner's we, else 0.
  - The write commits at the rising edge ending the grant cycle.
- Read path:
  - On a granted read, mem_rdata is captured into the winner's mX_rdata at the edge ending the grant cycle.
  - mX_rvalid is high for exactly the following cycle. Read latency = 1 cycle after gnt.
  - Writes produce no rvalid.
  - mX_rdata holds its value until the next read completes for that port.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees gnt high.
  - On the cycle gnt is high, the access is accepted. The requester may change or drop its signals in the next cycle.
  - Back-to-back accesses from one port with no contention are granted every cycle.
- last_gnt updates to the winner at every edge where a grant occurred; it is unchanged otherwise.
- Under continuous dual requests, grants alternate strictly 0,1,0,1...
- conflict_cnt increments on each cycle with m0_req & m1_req, and saturates at all-ones without wrapping.
- Same-address write/read between ports is resolved by grant order: a read granted after a write returns the new data.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- With the macro, inputs m0_lock and m1_lock (1 bit each) are added, together with a lock FSM with states UNLOCKED, LOCK0 and LOCK1:
  - UNLOCKED -> LOCKx when port x is granted with mx_lock = 1.
  - In LOCKx, only port x may be granted; the other port is blocked, and conflict cycles still count.
  - LOCKx -> UNLOCKED after a granted port-x access with mx_lock = 0 (that access executes), or after any cycle with mx_req = 0.
  - last_gnt still updates normally.
- Without the macro: no lock ports and no FSM; behaviour is pure round-robin.

Decomposition:
- Shared package/header dmem_arb_pkg:
  - AW/DW defaults.
  - Port-id constants PORT0 = 0, PORT1 = 1.
  - Lock FSM state encodings UNLOCKED = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2.
- One sub-module, rr_arb2: 2-way round-robin picker.
  - Inputs: req[1:0], last_gnt, and a mask (for the lock).
  - Output: one-hot gnt[1:0].

Test Plan:
- Port 0 only: write 0xDEADBEEF to addr 5, then read addr 5 -> m0_gnt high both cycles, mem_we = 1 then 0, m0_rvalid high one cycle after the read gnt, m0_rdata = 0xDEADBEEF; port 1 outputs stay 0.
- Both ports reading addr 3 and 7 every cycle for 6 cycles after reset -> grants 0,1,0,1,0,1; rdata 3 to port 0 and 7 to port 1; conflict_cnt = 6.
- Same-cycle port 0 write addr 2 = 0x55 and port 1 read addr 2 (last_gnt = 1) -> port 0 granted first; next cycle port 1 granted; m1_rdata = 0x55.
- rst_n low in the cycle of a pending port-1 write to addr 4 -> no gnt, mem_we = 0, addr 4 unchanged, rvalid = 0, conflict_cnt = 0.
- Force conflict_cnt near max (CNT_W = 4, 20 conflict cycles) -> counter stops at 15.
- With DMEM_ARB_LOCK_EN: port 1 locks, does 3 accesses with lock = 1 then 1 with lock = 0 while port 0 requests continuously -> m1_gnt for 4 cycles, m0_gnt 0 throughout, then m0_gnt next cycle.
